// File: rtl/fifo_axi4_bridge_pkg.sv
// -----------------------------------------------------------------------------
// fifo_axi4_pkg
// Shared types and AXI4 constants for the FIFO-to-AXI4 memory bridge.
//   cmd_t   : layout of the 65-bit command word (rd, byte address, word count)
//   state_e : bridge FSM state encoding
//   ID_W    : width of the AXI ID fields
// -----------------------------------------------------------------------------
package fifo_axi4_pkg;

   localparam int         ID_W          = 4;
   localparam logic [1:0] BURST_INCR    = 2'b01;
   localparam logic [3:0] CACHE_DEFAULT = 4'b0011;

   typedef struct packed {
      logic        rd;
      logic [31:0] addr;
      logic [31:0] count;
   } cmd_t;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_WR_ADDR = 3'd1,
      ST_WR_DATA = 3'd2,
      ST_WR_RESP = 3'd3,
      ST_RD_ADDR = 3'd4,
      ST_RD_DATA = 3'd5
   } state_e;

endpackage

// File: rtl/fifo_axi4_bridge_if.sv
// -----------------------------------------------------------------------------
// fifo_axi4_bridge_if
// AXI4 bus between the bridge (master modport) and the memory controller or
// its model (slave modport). Carries the AW, W, B, AR and R channels.
// Parameters: MEM_WIDTH (data bus width), ADDR_WIDTH (address width).
// -----------------------------------------------------------------------------
interface fifo_axi4_bridge_if #(
   parameter int MEM_WIDTH  = 32,
   parameter int ADDR_WIDTH = 32
);
   import fifo_axi4_pkg::*;

   logic [ID_W-1:0]        awid;
   logic [ADDR_WIDTH-1:0]  awaddr;
   logic [7:0]             awlen;
   logic [2:0]             awsize;
   logic [1:0]             awburst;
   logic                   awlock;
   logic [3:0]             awcache;
   logic [2:0]             awprot;
   logic [3:0]             awqos;
   logic                   awvalid;
   logic                   awready;

   logic [MEM_WIDTH-1:0]   wdata;
   logic [MEM_WIDTH/8-1:0] wstrb;
   logic                   wlast;
   logic                   wvalid;
   logic                   wready;

   logic [ID_W-1:0]        bid;
   logic [1:0]             bresp;
   logic                   bvalid;
   logic                   bready;

   logic [ID_W-1:0]        arid;
   logic [ADDR_WIDTH-1:0]  araddr;
   logic [7:0]             arlen;
   logic [2:0]             arsize;
   logic [1:0]             arburst;
   logic                   arlock;
   logic [3:0]             arcache;
   logic [2:0]             arprot;
   logic [3:0]             arqos;
   logic                   arvalid;
   logic                   arready;

   logic [ID_W-1:0]        rid;
   logic [MEM_WIDTH-1:0]   rdata;
   logic [1:0]             rresp;
   logic                   rlast;
   logic                   rvalid;
   logic                   rready;

   modport master (
      output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awqos, awvalid,
      input  awready,
      output wdata, wstrb, wlast, wvalid,
      input  wready,
      input  bid, bresp, bvalid,
      output bready,
      output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arqos, arvalid,
      input  arready,
      input  rid, rdata, rresp, rlast, rvalid,
      output rready
   );

   modport slave (
      input  awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awqos, awvalid,
      output awready,
      input  wdata, wstrb, wlast, wvalid,
      output wready,
      output bid, bresp, bvalid,
      input  bready,
      input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arqos, arvalid,
      output arready,
      output rid, rdata, rresp, rlast, rvalid,
      input  rready
   );

endinterface

// File: rtl/fifo_axi4_bridge_planner.sv
// -----------------------------------------------------------------------------
// axi_burst_planner
// Combinational sizing of the next AXI INCR burst:
//   beats = min(remaining, MAX_BURST, words left in the current 4 KB page)
// Ports:
//   page_off_i [11:0] : byte offset of the burst start within its 4 KB page
//   remain_i   [31:0] : words still to transfer for the command
//   beats_o    [8:0]  : beats in this burst
//   len_o      [7:0]  : AXI len field (beats - 1)
// -----------------------------------------------------------------------------
module axi_burst_planner #(
   parameter int MEM_WIDTH = 32,
   parameter int MAX_BURST = 16
) (
   input  logic [11:0] page_off_i,
   input  logic [31:0] remain_i,
   output logic [8:0]  beats_o,
   output logic [7:0]  len_o
);
   localparam int SIZE = $clog2(MEM_WIDTH/8);

   logic [12:0] page_words;
   logic [12:0] remain_sat;

   always_comb begin
      page_words = (13'd4096 - {1'b0, page_off_i}) >> SIZE;
      // Anything beyond 13 bits is far above MAX_BURST, so clamp it.
      remain_sat = (|remain_i[31:13]) ? 13'h1FFF : remain_i[12:0];

      beats_o = 9'(MAX_BURST);
      if (page_words < {4'd0, beats_o}) begin
         beats_o = page_words[8:0];
      end
      if (remain_sat < {4'd0, beats_o}) begin
         beats_o = remain_sat[8:0];
      end
      len_o = 8'(beats_o - 9'd1);
   end

endmodule

// File: rtl/fifo_axi4_bridge.sv
// -----------------------------------------------------------------------------
// fifo_axi4_bridge
// Bridges FIFO-style command / write-data / read-data streams to one AXI4
// master. Each command is split into INCR bursts that never cross 4 KB; only
// one burst is in flight and reads never overlap writes.
// Ports:
//   clk, reset        : clock, synchronous active-high reset
//   cmd_data[64:0]    : {rd, byte addr[31:0], word count[31:0]}; cmd_valid/cmd_ready
//   wr_data/valid/ready : write stream, passed straight to the W channel
//   rd_data/valid/ready : read stream, passed straight from the R channel
//   mig_init_done     : commands are accepted only after calibration
//   m_axi             : AXI4 master (fifo_axi4_bridge_if.master)
//   err_count[15:0]   : present only when RESP_CHECK_EN is defined; counts
//                       bursts answered with a non-OKAY response (saturating)
// -----------------------------------------------------------------------------
module fifo_axi4_bridge
   import fifo_axi4_pkg::*;
#(
   parameter int MEM_WIDTH  = 32,
   parameter int ADDR_WIDTH = 32,
   parameter int MAX_BURST  = 16,
   parameter int ID_VALUE   = 0
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [64:0]          cmd_data,
   input  logic                 cmd_valid,
   output logic                 cmd_ready,
   input  logic [MEM_WIDTH-1:0] wr_data,
   input  logic                 wr_valid,
   output logic                 wr_ready,
   output logic [MEM_WIDTH-1:0] rd_data,
   output logic                 rd_valid,
   input  logic                 rd_ready,
   input  logic                 mig_init_done,
   fifo_axi4_bridge_if.master   m_axi
`ifdef RESP_CHECK_EN
   ,
   output logic [15:0]          err_count
`endif
);
   localparam int SIZE = $clog2(MEM_WIDTH/8);

   localparam logic [2:0] IDLE    = ST_IDLE;
   localparam logic [2:0] WR_ADDR = ST_WR_ADDR;
   localparam logic [2:0] WR_DATA = ST_WR_DATA;
   localparam logic [2:0] WR_RESP = ST_WR_RESP;
   localparam logic [2:0] RD_ADDR = ST_RD_ADDR;
   localparam logic [2:0] RD_DATA = ST_RD_DATA;

   cmd_t                  cmd;
   logic [2:0]            state_q, state_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [31:0]           remain_q, remain_d;
   logic [7:0]            len_q;
   logic [8:0]            beats_q;
   logic [7:0]            beat_q;
   logic [8:0]            plan_beats;
   logic [7:0]            plan_len;
   logic                  load_plan;
   logic                  burst_done;
   logic                  awvalid_c, wvalid_c, wlast_c, bready_c, arvalid_c, rready_c;

   assign cmd = cmd_t'(cmd_data);

   // Sized from next-state address/remaining so len is already registered
   // when the address-valid cycle begins.
   axi_burst_planner #(
      .MEM_WIDTH (MEM_WIDTH),
      .MAX_BURST (MAX_BURST)
   ) u_planner (
      .page_off_i (addr_d[11:0]),
      .remain_i   (remain_d),
      .beats_o    (plan_beats),
      .len_o      (plan_len)
   );

   assign wlast_c = (state_q == WR_DATA) && (beat_q == len_q);

   always_comb begin
      state_d    = state_q;
      addr_d     = addr_q;
      remain_d   = remain_q;
      cmd_ready  = 1'b0;
      wr_ready   = 1'b0;
      rd_valid   = 1'b0;
      awvalid_c  = 1'b0;
      wvalid_c   = 1'b0;
      bready_c   = 1'b0;
      arvalid_c  = 1'b0;
      rready_c   = 1'b0;
      burst_done = 1'b0;
      case (state_q)
         IDLE: begin
            cmd_ready = mig_init_done & ~reset;
            if (cmd_ready && cmd_valid) begin
               addr_d   = ADDR_WIDTH'(cmd.addr);
               remain_d = cmd.count;
               // A zero-length command is consumed without bus traffic.
               if (cmd.count != 32'd0) begin
                  state_d = cmd.rd ? RD_ADDR : WR_ADDR;
               end
            end
         end
         WR_ADDR: begin
            awvalid_c = 1'b1;
            if (m_axi.awready) state_d = WR_DATA;
         end
         WR_DATA: begin
            wvalid_c = wr_valid;
            wr_ready = m_axi.wready;
            if (wr_valid && m_axi.wready && wlast_c) state_d = WR_RESP;
         end
         WR_RESP: begin
            bready_c = 1'b1;
            if (m_axi.bvalid) begin
               burst_done = 1'b1;
               state_d    = WR_ADDR;
            end
         end
         RD_ADDR: begin
            arvalid_c = 1'b1;
            if (m_axi.arready) state_d = RD_DATA;
         end
         RD_DATA: begin
            rd_valid = m_axi.rvalid;
            rready_c = rd_ready;
            if (m_axi.rvalid && rd_ready && m_axi.rlast) begin
               burst_done = 1'b1;
               state_d    = RD_ADDR;
            end
         end
         default: state_d = IDLE;
      endcase

      if (burst_done) begin
         addr_d   = addr_q + (ADDR_WIDTH'(beats_q) << SIZE);
         remain_d = remain_q - 32'(beats_q);
         if (remain_d == 32'd0) state_d = IDLE;
      end
   end

   assign load_plan = ((state_d == WR_ADDR) && (state_q != WR_ADDR)) ||
                      ((state_d == RD_ADDR) && (state_q != RD_ADDR));

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= IDLE;
         addr_q   <= '0;
         remain_q <= '0;
         len_q    <= '0;
         beats_q  <= '0;
         beat_q   <= '0;
      end else begin
         state_q  <= state_d;
         addr_q   <= addr_d;
         remain_q <= remain_d;
         if (load_plan) begin
            len_q   <= plan_len;
            beats_q <= plan_beats;
         end
         if (wvalid_c && m_axi.wready) begin
            beat_q <= wlast_c ? 8'd0 : beat_q + 8'd1;
         end
      end
   end

`ifdef RESP_CHECK_EN
   logic        rd_err_q;
   logic [15:0] err_q;
   logic        r_hs;
   logic        bad_burst;

   assign r_hs      = m_axi.rvalid && rready_c;
   assign bad_burst = (m_axi.bvalid && bready_c && (m_axi.bresp != 2'b00)) ||
                      (r_hs && m_axi.rlast && (rd_err_q || (m_axi.rresp != 2'b00)));

   // rd_err_q remembers a bad beat earlier in the current read burst.
   always_ff @(posedge clk) begin
      if (reset) begin
         rd_err_q <= 1'b0;
         err_q    <= '0;
      end else begin
         if (r_hs) rd_err_q <= m_axi.rlast ? 1'b0 : (rd_err_q | (m_axi.rresp != 2'b00));
         if (bad_burst && (err_q != 16'hFFFF)) err_q <= err_q + 16'd1;
      end
   end

   assign err_count = err_q;
`endif

   assign m_axi.awid    = ID_W'(ID_VALUE);
   assign m_axi.awaddr  = addr_q;
   assign m_axi.awlen   = len_q;
   assign m_axi.awsize  = 3'(SIZE);
   assign m_axi.awburst = BURST_INCR;
   assign m_axi.awlock  = 1'b0;
   assign m_axi.awcache = CACHE_DEFAULT;
   assign m_axi.awprot  = 3'b000;
   assign m_axi.awqos   = 4'b0000;
   assign m_axi.awvalid = awvalid_c;
   assign m_axi.wdata   = wr_data;
   assign m_axi.wstrb   = '1;
   assign m_axi.wlast   = wlast_c;
   assign m_axi.wvalid  = wvalid_c;
   assign m_axi.bready  = bready_c;
   assign m_axi.arid    = ID_W'(ID_VALUE);
   assign m_axi.araddr  = addr_q;
   assign m_axi.arlen   = len_q;
   assign m_axi.arsize  = 3'(SIZE);
   assign m_axi.arburst = BURST_INCR;
   assign m_axi.arlock  = 1'b0;
   assign m_axi.arcache = CACHE_DEFAULT;
   assign m_axi.arprot  = 3'b000;
   assign m_axi.arqos   = 4'b0000;
   assign m_axi.arvalid = arvalid_c;
   assign m_axi.rready  = rready_c;
   assign rd_data       = m_axi.rdata;

endmodule

// File: tb/tb_fifo_axi4_bridge.sv
// -----------------------------------------------------------------------------
// tb_fifo_axi4_bridge
// Scoreboard bench: commands are planned by a word-level reference model that
// queues the expected bursts and read data; an AXI slave memory model and a
// read-stream monitor pop and compare as the DUT presents traffic.
// Define RESP_CHECK_EN to also cover err_count.
// -----------------------------------------------------------------------------
module tb_fifo_axi4_bridge;
   import fifo_axi4_pkg::*;

   localparam int MW = 32;
   localparam int AW = 32;
   localparam int MB = 16;

   typedef struct packed {
      logic [31:0] addr;
      logic [7:0]  len;
   } burst_t;

   logic        clk = 1'b0;
   logic        reset;
   logic [64:0] cmd_data;
   logic        cmd_valid, cmd_ready;
   logic [31:0] wr_data;
   logic        wr_valid, wr_ready;
   logic [31:0] rd_data;
   logic        rd_valid, rd_ready;
   logic        mig_init_done;
`ifdef RESP_CHECK_EN
   logic [15:0] err_count;
`endif

   always #5 clk = ~clk;

   fifo_axi4_bridge_if #(.MEM_WIDTH(MW), .ADDR_WIDTH(AW)) axi ();

   fifo_axi4_bridge #(
      .MEM_WIDTH (MW), .ADDR_WIDTH (AW), .MAX_BURST (MB), .ID_VALUE (0)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .cmd_data      (cmd_data),
      .cmd_valid     (cmd_valid),
      .cmd_ready     (cmd_ready),
      .wr_data       (wr_data),
      .wr_valid      (wr_valid),
      .wr_ready      (wr_ready),
      .rd_data       (rd_data),
      .rd_valid      (rd_valid),
      .rd_ready      (rd_ready),
      .mig_init_done (mig_init_done),
      .m_axi         (axi.master)
`ifdef RESP_CHECK_EN
      ,
      .err_count     (err_count)
`endif
   );

   int          checks = 0;
   int          failures = 0;
   int          exp_err = 0;
   bit          toggle_mode = 0;
   burst_t      exp_aw[$], exp_ar[$], aw_log[$], ar_log[$];
   logic [31:0] wr_q[$], exp_rd[$];
   logic [31:0] ref_mem [0:4095];
   logic [31:0] slv_mem [0:4095];

   bit          w_active = 0, b_pending = 0, r_active = 0;
   logic [31:0] w_addr, r_addr;
   int          w_beat, w_len, r_beat, r_len;

   task automatic check(string name, logic [63:0] got, logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %0h, required %0h", name, got, exp);
      end
   endtask

   task automatic unexpected(string name, logic [63:0] got);
      checks++;
      failures++;
      $display("FAIL %s: got %0h, required nothing pending", name, got);
   endtask

   // Reference model: walk the command in words, cutting at MAX_BURST and at
   // every 4 KB page edge.
   task automatic plan_cmd(bit rd, logic [31:0] addr, int cnt, bit seq);
      logic [31:0] a = addr;
      int rem = cnt;
      int room, b, idx;
      logic [31:0] d;
      int nxt = 1;
      while (rem > 0) begin
         room = (4096 - int'(a % 32'd4096)) / 4;
         b = rem;
         if (b > MB) b = MB;
         if (b > room) b = room;
         if (rd) exp_ar.push_back('{addr: a, len: 8'(b - 1)});
         else    exp_aw.push_back('{addr: a, len: 8'(b - 1)});
         for (int i = 0; i < b; i++) begin
            idx = (int'(a[13:2]) + i) % 4096;
            if (rd) begin
               exp_rd.push_back(ref_mem[idx]);
            end else begin
               d = seq ? 32'(nxt) : $urandom;
               nxt++;
               ref_mem[idx] = d;
               wr_q.push_back(d);
            end
         end
         a = a + 32'(b * 4);
         rem = rem - b;
      end
   endtask

   task automatic send_cmd(bit rd, logic [31:0] addr, int cnt, bit seq);
      bit ok = 0;
      plan_cmd(rd, addr, cnt, seq);
      @(posedge clk); #1;
      cmd_data  = {rd, addr, 32'(cnt)};
      cmd_valid = 1'b1;
      for (int t = 0; t < 5000; t++) begin
         @(negedge clk);
         if (cmd_ready) begin
            ok = 1;
            break;
         end
      end
      check("cmd_accept", 64'(ok), 64'(1));
      @(posedge clk); #1;
      cmd_valid = 1'b0;
   endtask

   task automatic wait_idle();
      bit ok = 0;
      for (int t = 0; t < 5000; t++) begin
         @(negedge clk);
         if (cmd_ready && wr_q.size() == 0 && exp_rd.size() == 0 &&
             !w_active && !b_pending && !r_active) begin
            ok = 1;
            break;
         end
      end
      check("wait_idle", 64'(ok), 64'(1));
   endtask

   // Write-data source.
   initial begin
      wr_valid = 1'b0;
      wr_data  = '0;
      forever begin
         @(posedge clk); #1;
         wr_valid = (wr_q.size() > 0) && ($urandom % 4 != 0);
         wr_data  = (wr_q.size() > 0) ? wr_q[0] : 32'd0;
         @(negedge clk);
         if (wr_valid && wr_ready) void'(wr_q.pop_front());
      end
   end

   // Read-data sink and monitor.
   initial begin
      rd_ready = 1'b0;
      forever begin
         @(posedge clk); #1;
         rd_ready = toggle_mode ? ~rd_ready : ($urandom % 3 != 0);
         @(negedge clk);
         if (axi.rvalid) check("rready_mirror", 64'({rd_valid, axi.rready}), 64'({1'b1, rd_ready}));
         if (rd_valid && rd_ready) begin
            if (exp_rd.size() == 0) unexpected("rd_beat", 64'(rd_data));
            else check("rd_data", 64'(rd_data), 64'(exp_rd.pop_front()));
         end
      end
   end

   // AXI slave memory model with the burst scoreboard.
   initial begin
      bit          aw_hs, w_hs, b_hs, ar_hs, r_hs;
      logic [1:0]  b_resp_val;
      bit          r_err;
      burst_t      e;
      axi.awready = 0; axi.wready = 0; axi.bvalid = 0; axi.bresp = 0; axi.bid = '0;
      axi.arready = 0; axi.rvalid = 0; axi.rresp = 0; axi.rdata = '0; axi.rlast = 0;
      axi.rid = '0;
      b_resp_val = 2'b00;
      r_err = 0;
      forever begin
         @(negedge clk);
         aw_hs = axi.awvalid && axi.awready;
         w_hs  = axi.wvalid && axi.wready;
         b_hs  = axi.bvalid && axi.bready;
         ar_hs = axi.arvalid && axi.arready;
         r_hs  = axi.rvalid && axi.rready;
         if (aw_hs) begin
            check("aw_outstanding", 64'({w_active, b_pending, r_active}), 64'(0));
            check("aw_const", 64'({axi.awsize, axi.awburst, axi.awlock, axi.awcache,
                                   axi.awprot, axi.awqos, axi.awid}),
                  64'({3'd2, 2'b01, 1'b0, 4'b0011, 3'd0, 4'd0, 4'd0}));
            aw_log.push_back('{addr: axi.awaddr, len: axi.awlen});
            if (exp_aw.size() == 0) unexpected("aw_burst", 64'(axi.awaddr));
            else begin
               e = exp_aw.pop_front();
               check("awaddr", 64'(axi.awaddr), 64'(e.addr));
               check("awlen", 64'(axi.awlen), 64'(e.len));
            end
            w_active = 1; w_addr = axi.awaddr; w_len = int'(axi.awlen); w_beat = 0;
         end
         if (w_hs) begin
            if (!w_active) unexpected("w_beat", 64'(axi.wdata));
            else begin
               check("wlast", 64'({axi.wlast, axi.wstrb}), 64'({(w_beat == w_len), 4'hF}));
               slv_mem[(int'(w_addr[13:2]) + w_beat) % 4096] = axi.wdata;
               if (w_beat == w_len) begin
                  w_active = 0;
                  b_pending = 1;
                  b_resp_val = ($urandom % 4 == 0) ? 2'b10 : 2'b00;
               end else w_beat++;
            end
         end
         if (b_hs) begin
            b_pending = 0;
            if (axi.bresp != 2'b00) exp_err++;
         end
         if (ar_hs) begin
            check("ar_outstanding", 64'({w_active, b_pending, r_active}), 64'(0));
            check("ar_const", 64'({axi.arsize, axi.arburst, axi.arlock, axi.arcache,
                                   axi.arprot, axi.arqos, axi.arid}),
                  64'({3'd2, 2'b01, 1'b0, 4'b0011, 3'd0, 4'd0, 4'd0}));
            ar_log.push_back('{addr: axi.araddr, len: axi.arlen});
            if (exp_ar.size() == 0) unexpected("ar_burst", 64'(axi.araddr));
            else begin
               e = exp_ar.pop_front();
               check("araddr", 64'(axi.araddr), 64'(e.addr));
               check("arlen", 64'(axi.arlen), 64'(e.len));
            end
            r_active = 1; r_addr = axi.araddr; r_len = int'(axi.arlen); r_beat = 0; r_err = 0;
         end
         if (r_hs) begin
            r_err = r_err | (axi.rresp != 2'b00);
            if (r_beat == r_len) begin
               r_active = 0;
               if (r_err) exp_err++;
            end else r_beat++;
         end
         @(posedge clk); #1;
         axi.awready = ($urandom % 2 == 0);
         axi.wready  = ($urandom % 4 != 0);
         axi.arready = ($urandom % 2 == 0);
         axi.bvalid  = b_pending;
         axi.bresp   = b_resp_val;
         if (r_hs || !axi.rvalid) begin
            axi.rvalid = r_active && ($urandom % 3 != 0);
            axi.rresp  = ($urandom % 8 == 0) ? 2'b10 : 2'b00;
         end
         axi.rdata = slv_mem[(int'(r_addr[13:2]) + r_beat) % 4096];
         axi.rlast = (r_beat == r_len);
      end
   end

   burst_t dir_aw [5] = '{'{32'h100, 8'd3}, '{32'h0, 8'd15}, '{32'h40, 8'd3},
                          '{32'hFF8, 8'd1}, '{32'h1000, 8'd1}};
   burst_t dir_ar [3] = '{'{32'h100, 8'd3}, '{32'hFF8, 8'd1}, '{32'h1000, 8'd1}};

   initial begin
      int cnt;
      reset = 1'b1;
      cmd_valid = 1'b0;
      cmd_data = '0;
      mig_init_done = 1'b1;
      r_addr = '0; w_addr = '0; r_beat = 0; r_len = 0; w_beat = 0; w_len = 0;
      for (int i = 0; i < 4096; i++) begin
         ref_mem[i] = 32'(i) * 32'h9E3779B1;
         slv_mem[i] = 32'(i) * 32'h9E3779B1;
      end
      repeat (2) @(negedge clk);
      check("reset_ctrl", 64'({cmd_ready, axi.awvalid, axi.wvalid, axi.bready,
                               axi.arvalid, axi.rready, rd_valid}), 64'(0));
`ifdef RESP_CHECK_EN
      check("err_count_reset", 64'(err_count), 64'(0));
`endif
      @(posedge clk); #1;
      reset = 1'b0;

      // Directed: simple write/readback, multi-burst, 4 KB crossing.
      send_cmd(0, 32'h100, 4, 1);
      send_cmd(1, 32'h100, 4, 0);
      send_cmd(0, 32'h0, 20, 0);
      send_cmd(0, 32'hFF8, 4, 0);
      send_cmd(1, 32'hFF8, 4, 0);
      wait_idle();
      check("aw_log_size", 64'(aw_log.size()), 64'(5));
      for (int i = 0; i < 5 && i < aw_log.size(); i++) check("aw_log", 64'(aw_log[i]), 64'(dir_aw[i]));
      check("ar_log_size", 64'(ar_log.size()), 64'(3));
      for (int i = 0; i < 3 && i < ar_log.size(); i++) check("ar_log", 64'(ar_log[i]), 64'(dir_ar[i]));

      // Calibration gating.
      mig_init_done = 1'b0;
      plan_cmd(0, 32'h200, 2, 0);
      @(posedge clk); #1;
      cmd_data = {1'b0, 32'h200, 32'd2};
      cmd_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("cmd_ready_no_init", 64'(cmd_ready), 64'(0));
      end
      @(posedge clk); #1;
      mig_init_done = 1'b1;
      @(negedge clk);
      check("cmd_ready_init", 64'(cmd_ready), 64'(1));
      @(posedge clk); #1;
      cmd_valid = 1'b0;
      wait_idle();

      // Toggling read sink, then a zero-length read.
      toggle_mode = 1;
      send_cmd(1, 32'h0, 20, 0);
      send_cmd(1, 32'h500, 0, 0);
      wait_idle();
      toggle_mode = 0;

      // Randomized commands.
      for (int n = 0; n < 30; n++) begin
         cnt = ($urandom % 8 == 0) ? 0 : int'($urandom_range(1, 40));
         send_cmd(bit'($urandom % 2), 32'($urandom % 32'hC00) * 32'd4, cnt, 0);
      end
      wait_idle();
      check("leftover", 64'(exp_aw.size() + exp_ar.size() + exp_rd.size() + wr_q.size()), 64'(0));
`ifdef RESP_CHECK_EN
      check("err_count", 64'(err_count), 64'(16'(exp_err)));
`endif

      @(posedge clk); #1;
      reset = 1'b1;
      @(negedge clk);
      check("cmd_ready_in_reset", 64'(cmd_ready), 64'(0));
      @(posedge clk); #1;
      reset = 1'b0;
      @(negedge clk);
`ifdef RESP_CHECK_EN
      check("err_count_after_reset", 64'(err_count), 64'(0));
`endif
      $display("TB_INFO injected_error_responses=%0d", exp_err);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
